// File: rtl/divisor_configurable.sv
// Multi-cycle restoring integer divider with a signed/unsigned mode, 1 or 2 quotient bits per clock,
// divide-by-zero detection and a four-phase Start/Done handshake.
//
// state | meaning
// IDLE  | waiting for Start; operands are captured on acceptance
// CALC  | one restoring step per retired quotient bit, MSB first
// FIX   | apply result signs and load Coc/Res
// DONE  | Done held until Start falls
module divisor_configurable #(
    parameter int tamanyo    = 16,
    parameter int BITS_CICLO = 1
) (
    input  logic               CLK,
    input  logic               RSTa,
    input  logic               Start,
    input  logic               Signed,
    input  logic [tamanyo-1:0] Num,
    input  logic [tamanyo-1:0] Den,
    output logic [tamanyo-1:0] Coc,
    output logic [tamanyo-1:0] Res,
    output logic               Done,
    output logic               Busy,
    output logic               DivZero
);

    localparam int W  = tamanyo;
    localparam int N  = tamanyo / BITS_CICLO;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [W-1:0]    dvd_q, dvd_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [W:0]      rem_q, rem_d;
    logic [W-1:0]    coc_q, coc_d;
    logic [W-1:0]    res_q, res_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            divzero_q, divzero_d;

    logic            num_neg, den_neg;
    logic [W-1:0]    num_mag, den_mag;
    logic [W:0]      step_rem;
    logic [W-1:0]    step_dvd;

    assign num_neg = Signed & Num[W-1];
    assign den_neg = Signed & Den[W-1];
    assign num_mag = num_neg ? -Num : Num;
    assign den_mag = den_neg ? -Den : Den;

    // The dividend register doubles as the quotient: each step shifts a dividend bit out and a quotient bit in.
    always_comb begin
        step_rem = rem_q;
        step_dvd = dvd_q;
        for (int i = 0; i < BITS_CICLO; i++) begin
            step_rem = {step_rem[W-1:0], step_dvd[W-1]};
            if (step_rem >= {1'b0, dvs_q}) begin
                step_rem = step_rem - {1'b0, dvs_q};
                step_dvd = {step_dvd[W-2:0], 1'b1};
            end else begin
                step_dvd = {step_dvd[W-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        coc_d     = coc_q;
        res_d     = res_q;
        done_d    = done_q;
        busy_d    = busy_q;
        divzero_d = divzero_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    qneg_d    = num_neg ^ den_neg;
                    rneg_d    = num_neg;
                    dvd_d     = num_mag;
                    dvs_d     = den_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    divzero_d = (Den == '0);
                    if (Den == '0) begin
                        coc_d   = '1;
                        res_d   = Num;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                coc_d   = qneg_q ? -dvd_q : dvd_q;
                res_d   = rneg_q ? -rem_q[W-1:0] : rem_q[W-1:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (!Start) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            coc_q     <= '0;
            res_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            coc_q     <= coc_d;
            res_q     <= res_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            divzero_q <= divzero_d;
        end
    end

    assign Coc     = coc_q;
    assign Res     = res_q;
    assign Done    = done_q;
    assign Busy    = busy_q;
    assign DivZero = divzero_q;

endmodule

// File: tb/tb_divisor_configurable.sv
// Directed bench for divisor_configurable: one instance retiring 1 bit per clock, one retiring 2.
module tb_divisor_configurable;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a [2];
    logic        sgn_a   [2];
    logic [15:0] num_a   [2];
    logic [15:0] den_a   [2];
    logic [15:0] coc_a   [2];
    logic [15:0] res_a   [2];
    logic        done_a  [2];
    logic        busy_a  [2];
    logic        dz_a    [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    divisor_configurable #(.tamanyo(16), .BITS_CICLO(1)) dut1 (
        .CLK(clk), .RSTa(rst_n), .Start(start_a[0]), .Signed(sgn_a[0]),
        .Num(num_a[0]), .Den(den_a[0]), .Coc(coc_a[0]), .Res(res_a[0]),
        .Done(done_a[0]), .Busy(busy_a[0]), .DivZero(dz_a[0])
    );

    divisor_configurable #(.tamanyo(16), .BITS_CICLO(2)) dut2 (
        .CLK(clk), .RSTa(rst_n), .Start(start_a[1]), .Signed(sgn_a[1]),
        .Num(num_a[1]), .Den(den_a[1]), .Coc(coc_a[1]), .Res(res_a[1]),
        .Done(done_a[1]), .Busy(busy_a[1]), .DivZero(dz_a[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full handshake: accept, wait for Done (bounded), check results, optionally hold Start, then release.
    task automatic run_op(input int d, input string tag, input logic sg,
                          input logic [15:0] n, input logic [15:0] dn,
                          input logic [15:0] ec, input logic [15:0] er, input logic edz,
                          input int elat, input int hold, input bit scramble);
        int lat;
        int busy_bad;
        @(negedge clk);
        sgn_a[d]   = sg;
        num_a[d]   = n;
        den_a[d]   = dn;
        start_a[d] = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " busy_after_accept"}, busy_a[d], !edz);
        if (scramble) begin
            num_a[d] = ~n;
            den_a[d] = 16'h0000;
            sgn_a[d] = ~sg;
        end
        lat      = 0;
        busy_bad = 0;
        while (!done_a[d] && lat < 40) begin
            if (!busy_a[d]) busy_bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, lat, elat);
        chk({tag, " busy_gaps"}, busy_bad, 0);
        chk({tag, " coc"}, coc_a[d], ec);
        chk({tag, " res"}, res_a[d], er);
        chk({tag, " divzero"}, dz_a[d], edz);
        chk({tag, " busy_at_done"}, busy_a[d], 0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold_done"}, done_a[d], 1);
            chk({tag, " hold_busy"}, busy_a[d], 0);
            chk({tag, " hold_coc"}, coc_a[d], ec);
        end
        start_a[d] = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " done_cleared"}, done_a[d], 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            start_a[d] = 1'b0;
            sgn_a[d]   = 1'b0;
            num_a[d]   = '0;
            den_a[d]   = '0;
        end
        rst_n = 1'b0;
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("reset coc", coc_a[d], 0);
            chk("reset res", res_a[d], 0);
            chk("reset done", done_a[d], 0);
            chk("reset busy", busy_a[d], 0);
            chk("reset divzero", dz_a[d], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // 1 bit per clock: latency 17
        run_op(0, "b1 15/3",      1'b1, 16'd15,    16'd3,    16'd5,    16'd0,    1'b0, 17, 0, 1'b0);
        run_op(0, "b1 17/-3",     1'b1, 16'd17,    16'hFFFD, 16'hFFFB, 16'd2,    1'b0, 17, 0, 1'b0);
        run_op(0, "b1 -17/3",     1'b1, 16'hFFEF,  16'd3,    16'hFFFB, 16'hFFFE, 1'b0, 17, 0, 1'b0);
        run_op(0, "b1 -23/-5",    1'b1, 16'hFFE9,  16'hFFFB, 16'd4,    16'hFFFD, 1'b0, 17, 0, 1'b0);
        run_op(0, "b1 uFFFF/2",   1'b0, 16'hFFFF,  16'd2,    16'h7FFF, 16'd1,    1'b0, 17, 0, 1'b0);
        run_op(0, "b1 sFFFF/2",   1'b1, 16'hFFFF,  16'd2,    16'h0000, 16'hFFFF, 1'b0, 17, 0, 1'b0);
        run_op(0, "b1 ovf",       1'b1, 16'h8000,  16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17, 0, 1'b0);
        run_op(0, "b1 dz u",      1'b0, 16'h1234,  16'h0000, 16'hFFFF, 16'h1234, 1'b1, 0,  0, 1'b0);
        run_op(0, "b1 dz s",      1'b1, 16'h8005,  16'h0000, 16'hFFFF, 16'h8005, 1'b1, 0,  0, 1'b0);
        run_op(0, "b1 hold",      1'b1, 16'd15,    16'd3,    16'd5,    16'd0,    1'b0, 17, 4, 1'b0);
        run_op(0, "b1 scramble",  1'b1, 16'hFFE9,  16'hFFFB, 16'd4,    16'hFFFD, 1'b0, 17, 0, 1'b1);

        // 2 bits per clock: latency 9
        run_op(1, "b2 15/3",      1'b1, 16'd15,    16'd3,    16'd5,    16'd0,    1'b0, 9, 0, 1'b0);
        run_op(1, "b2 17/-3",     1'b1, 16'd17,    16'hFFFD, 16'hFFFB, 16'd2,    1'b0, 9, 0, 1'b0);
        run_op(1, "b2 -17/3",     1'b1, 16'hFFEF,  16'd3,    16'hFFFB, 16'hFFFE, 1'b0, 9, 0, 1'b0);
        run_op(1, "b2 -23/-5",    1'b1, 16'hFFE9,  16'hFFFB, 16'd4,    16'hFFFD, 1'b0, 9, 0, 1'b0);
        run_op(1, "b2 uFFFF/FF",  1'b0, 16'hFFFF,  16'h00FF, 16'h0101, 16'h0000, 1'b0, 9, 0, 1'b0);
        run_op(1, "b2 1000/7",    1'b1, 16'h03E8,  16'h0007, 16'h008E, 16'h0006, 1'b0, 9, 0, 1'b0);
        run_op(1, "b2 -1000/7",   1'b1, 16'hFC18,  16'h0007, 16'hFF72, 16'hFFFA, 1'b0, 9, 0, 1'b0);
        run_op(1, "b2 u8000/8001",1'b0, 16'h8000,  16'h8001, 16'h0000, 16'h8000, 1'b0, 9, 0, 1'b0);
        run_op(1, "b2 7FFF/-max", 1'b1, 16'h7FFF,  16'h8000, 16'h0000, 16'h7FFF, 1'b0, 9, 0, 1'b0);
        run_op(1, "b2 ovf",       1'b1, 16'h8000,  16'hFFFF, 16'h8000, 16'h0000, 1'b0, 9, 0, 1'b0);
        run_op(1, "b2 dz",        1'b0, 16'h1234,  16'h0000, 16'hFFFF, 16'h1234, 1'b1, 0, 0, 1'b0);

        // Reset in the middle of CALC on the 1-bit instance, which still shows 4 / 0xFFFD
        @(negedge clk);
        sgn_a[0]   = 1'b1;
        num_a[0]   = 16'd17;
        den_a[0]   = 16'd3;
        start_a[0] = 1'b1;
        @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        chk("midcalc busy", busy_a[0], 1);
        rst_n = 1'b0;
        #1;
        start_a[0] = 1'b0;
        chk("abort coc", coc_a[0], 0);
        chk("abort res", res_a[0], 0);
        chk("abort done", done_a[0], 0);
        chk("abort busy", busy_a[0], 0);
        chk("abort divzero", dz_a[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, "b1 after reset", 1'b1, 16'd17, 16'd3, 16'd5, 16'd2, 1'b0, 17, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
